// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, with borrow-out.
//   Each RUN cycle resolves one bit, LSB first, through a single borrow flop.
//   A start/busy/done handshake lets a controller issue one operation at a
//   time and collect registered results.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high
//   start  request pulse, sampled only while idle
//   a      minuend, captured on the accepted start
//   b      subtrahend, captured on the accepted start
//   bin    borrow-in, captured on the accepted start
//   diff   registered result, held until the next completion or reset
//   bout   registered borrow-out (1 when a < b + bin, unsigned)
//   busy   high while bits are being resolved
//   done   one-cycle pulse in the cycle diff/bout first show a new result
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  // Holds the WIDTH-1 bits already resolved; the bit being resolved this
  // cycle is combined in res_nx so the final edge can load diff directly.
  logic [WIDTH-2:0] res;
  logic             borrow;
  logic [CW-1:0]    count;

  logic             d;
  logic             borrow_nx;
  logic [WIDTH-1:0] res_nx;

  // One full-subtractor slice on the current LSBs.
  always_comb begin
    d         = sa[0] ^ sb[0] ^ borrow;
    borrow_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    res_nx    = {d, res};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= borrow_nx;
          res    <= res_nx[WIDTH-1:1];
          count  <= count + 1'b1;
          if (count == LAST) begin
            diff  <= res_nx;
            bout  <= borrow_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: a WIDTH=4 and a WIDTH=8 instance share
// clock and reset. Expected results are queued when a start is driven and
// popped by a monitor whenever done pulses (value and latency checked there).
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start4, bin4, bout4, busy4, done4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, bout8, busy8, done8;
  logic [7:0] a8, b8, diff8;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  exp_t q4[$];
  exp_t q8[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [8:0] model(input bit w8, input logic [7:0] a, input logic [7:0] b,
                                       input logic bin);
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b} - {8'h00, bin};
    if (w8) return t;
    return {t[4], 4'h0, t[3:0]};
  endfunction

  // Scoreboard monitor: result value and start-to-done latency.
  logic pd4 = 1'b0;
  logic pd8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      chk("done4_back_to_back", pd4, 0);
      if (q4.size() == 0) chk("done4_unexpected", 1, 0);
      else begin
        e = q4.pop_front();
        chk("diff4", diff4, e.diff);
        chk("bout4", bout4, e.bout);
        chk("latency4", cyc, e.cyc + 5);
      end
    end
    pd4 = (done4 === 1'b1);
    if (done8 === 1'b1) begin
      chk("done8_back_to_back", pd8, 0);
      if (q8.size() == 0) chk("done8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        chk("diff8", diff8, e.diff);
        chk("bout8", bout8, e.bout);
        chk("latency8", cyc, e.cyc + 9);
      end
    end
    pd8 = (done8 === 1'b1);
  end

  // One complete operation: busy length, busy low in FIN, hold in IDLE.
  task automatic op(input bit w8, input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                    input logic [7:0] ed, input logic eb, input string tag);
    int   w;
    int   nb;
    bit   seen;
    exp_t e;
    w    = w8 ? 8 : 4;
    nb   = 0;
    seen = 1'b0;
    @(negedge clk);
    e.diff = ed;
    e.bout = eb;
    e.cyc  = cyc;
    if (w8) begin
      a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
      q8.push_back(e);
    end else begin
      a4 = ia[3:0]; b4 = ib[3:0]; bin4 = ibin; start4 = 1'b1;
      q4.push_back(e);
    end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    for (int i = 0; i < w + 4; i++) begin
      if ((w8 ? done8 : done4) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if ((w8 ? busy8 : busy4) === 1'b1) nb++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_busy_cycles"}, nb, w);
    chk({tag, "_busy_in_fin"}, w8 ? busy8 : busy4, 0);
    @(negedge clk);
    chk({tag, "_hold_diff"}, w8 ? diff8 : {4'h0, diff4}, ed);
    chk({tag, "_hold_bout"}, w8 ? bout8 : bout4, eb);
    chk({tag, "_done_low"}, w8 ? done8 : done4, 0);
  endtask

  vec_t tbl[10];

  initial begin
    logic [8:0] r;
    int         nacc;
    int         nd;

    tbl[0] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0};
    tbl[1] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1};
    tbl[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    tbl[3] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0};
    tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    tbl[5] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1};
    tbl[6] = '{4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b1};
    tbl[7] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0};
    tbl[8] = '{4'b0010, 4'b0011, 1'b0, 4'b1111, 1'b1};
    tbl[9] = '{4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0};

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_diff4", diff4, 0);
    chk("rst_bout4", bout4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_diff8", diff8, 0);
    chk("rst_bout8", bout8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      op(1'b0, {4'h0, tbl[i].a}, {4'h0, tbl[i].b}, tbl[i].bin,
         {4'h0, tbl[i].diff}, tbl[i].bout, "tbl");

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          r = model(1'b0, 8'(x), 8'(y), 1'(c));
          op(1'b0, 8'(x), 8'(y), 1'(c), r[7:0], r[8], "w4");
        end

    // start held high; operands scrambled whenever the block is not idle
    @(negedge clk);
    nacc   = 0;
    start4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy4 === 1'b0 && done4 === 1'b0) begin
        exp_t e;
        a4 = 4'b1001; b4 = 4'b0100; bin4 = 1'b0;
        e.diff = 8'h05; e.bout = 1'b0; e.cyc = cyc;
        q4.push_back(e);
        nacc++;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    chk("held_ops", nacc, 4);
    for (int i = 0; i < 12 && q4.size() != 0; i++) @(negedge clk);
    chk("held_drain", q4.size(), 0);
    repeat (2) @(negedge clk);
    chk("held_hold_diff", diff4, 4'b0101);

    // reset on the second RUN edge aborts the operation
    a4 = 4'b0101; b4 = 4'b0011; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_diff", diff4, 0);
    chk("abort_bout", bout4, 0);
    rst = 1'b0;
    nd  = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    op(1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "after_rst");

    r = model(1'b1, 8'h5a, 8'h5a, 1'b1); op(1'b1, 8'h5a, 8'h5a, 1'b1, r[7:0], r[8], "w8b");
    r = model(1'b1, 8'h00, 8'hff, 1'b1); op(1'b1, 8'h00, 8'hff, 1'b1, r[7:0], r[8], "w8b");
    r = model(1'b1, 8'hff, 8'h00, 1'b0); op(1'b1, 8'hff, 8'h00, 1'b0, r[7:0], r[8], "w8b");
    r = model(1'b1, 8'h00, 8'h01, 1'b0); op(1'b1, 8'h00, 8'h01, 1'b0, r[7:0], r[8], "w8b");
    r = model(1'b1, 8'h80, 8'h01, 1'b0); op(1'b1, 8'h80, 8'h01, 1'b0, r[7:0], r[8], "w8b");
    for (int i = 0; i < 1200; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r  = model(1'b1, ra, rb, rc);
      op(1'b1, ra, rb, rc, r[7:0], r[8], "w8");
    end

    repeat (2) @(negedge clk);
    chk("final_q4_empty", q4.size(), 0);
    chk("final_q8_empty", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
